// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of a five-stage RISC-V pipeline.
// Takes the EX/MEM bundle and runs loads/stores on a req/ready data bus.
// Registers the MEM/WB bundle and stalls upstream while a bus access is open.
// An access is aborted after MEM_TIMEOUT waiting cycles; 0 disables the timeout.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/HU/W
// accesses in IDLE instead of silently aligning them.
module mem_stage #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_data,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [4:0]  ex_mem_rd_addr,
  input  logic        ex_mem_reg_write_en,
  input  logic        ex_mem_mem_read_en,
  input  logic        ex_mem_mem_write_en,
  input  logic [1:0]  ex_mem_mem_to_reg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_wb_valid,
  output logic        mem_wb_reg_write_en,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_load_data,
  output logic [4:0]  mem_wb_rd_addr,
  output logic [1:0]  mem_wb_mem_to_reg,
  output logic        mem_bus_err,
  output logic        mem_misaligned
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [2:0] F_W           = 3'b010;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
  localparam bit         TIMEOUT_EN    = (MEM_TIMEOUT != 0);

  state_t      state;
  state_t      state_next;
  logic [7:0]  tmo_cnt;

  // Fields captured when a memory access is accepted
  logic [31:0] cap_alu;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [2:0]  cap_funct3;
  logic [4:0]  cap_rd;
  logic        cap_reg_write_en;
  logic [1:0]  cap_mem_to_reg;

  logic is_mem;
  logic misaligned;
  logic accept_mem;
  logic timeout_hit;

  // Byte offset of the accessed lane: H ignores addr[0], W ignores addr[1:0]
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] base;
    case (f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << lane_offset(f3, a);
  endfunction

  // Store data is replicated into every lane so the bus only needs byte enables
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> {lane_offset(f3, a), 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign is_mem = ex_mem_mem_read_en | ex_mem_mem_write_en;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ex_mem_valid && is_mem &&
                      (((ex_mem_funct3[1:0] == 2'b01) && ex_mem_alu_result[0]) ||
                       ((ex_mem_funct3 == F_W) && (ex_mem_alu_result[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign accept_mem  = (state == IDLE) && ex_mem_valid && is_mem && !misaligned;
  // dmem_ready has priority over the timeout in the same cycle
  assign timeout_hit = (state == BUS) && !dmem_ready && TIMEOUT_EN &&
                       ((tmo_cnt + 8'd1) == TIMEOUT_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every register samples pre-edge values
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch)
    state_next = state;
    case (state)
      IDLE:    if (accept_mem) state_next = BUS;
      BUS:     if (dmem_ready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs of the BUS state
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    if (state == BUS) begin
      dmem_req  = 1'b1;
      mem_stall = 1'b1;
    end
  end

  assign dmem_we    = cap_we;
  assign dmem_addr  = {cap_alu[31:2], 2'b00};
  assign dmem_be    = cap_be;
  assign dmem_wdata = cap_wdata;

  // Capture the access on acceptance and count unanswered BUS cycles
  always_ff @(posedge clk) begin
    // NOTE: captured fields are reset too, so every dmem_* output reads 0 after reset
    if (rst) begin
      cap_alu          <= '0;
      cap_wdata        <= '0;
      cap_be           <= '0;
      cap_we           <= 1'b0;
      cap_funct3       <= '0;
      cap_rd           <= '0;
      cap_reg_write_en <= 1'b0;
      cap_mem_to_reg   <= '0;
      tmo_cnt          <= '0;
    end else if (accept_mem) begin
      cap_alu          <= ex_mem_alu_result;
      cap_wdata        <= store_data(ex_mem_funct3, ex_mem_rs2_data);
      cap_be           <= byte_enable(ex_mem_funct3, ex_mem_alu_result[1:0]);
      cap_we           <= ~ex_mem_mem_read_en;  // read wins when both are set
      cap_funct3       <= ex_mem_funct3;
      cap_rd           <= ex_mem_rd_addr;
      cap_reg_write_en <= ex_mem_reg_write_en;
      cap_mem_to_reg   <= ex_mem_mem_to_reg;
      tmo_cnt          <= '0;
    end else if ((state == BUS) && !dmem_ready) begin
      tmo_cnt          <= tmo_cnt + 8'd1;
    end
  end

  // MEM/WB register: a bubble every cycle unless an instruction retires
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_valid        <= 1'b0;
      mem_wb_reg_write_en <= 1'b0;
      mem_wb_alu_result   <= '0;
      mem_wb_load_data    <= '0;
      mem_wb_rd_addr      <= '0;
      mem_wb_mem_to_reg   <= '0;
      mem_bus_err         <= 1'b0;
    end else begin
      mem_wb_valid        <= 1'b0;
      mem_wb_reg_write_en <= 1'b0;
      mem_wb_alu_result   <= '0;
      mem_wb_load_data    <= '0;
      mem_wb_rd_addr      <= '0;
      mem_wb_mem_to_reg   <= '0;
      mem_bus_err         <= 1'b0;
      if (state == IDLE) begin
        if (ex_mem_valid && !is_mem) begin
          mem_wb_valid        <= 1'b1;
          mem_wb_reg_write_en <= ex_mem_reg_write_en;
          mem_wb_alu_result   <= ex_mem_alu_result;
          mem_wb_rd_addr      <= ex_mem_rd_addr;
          mem_wb_mem_to_reg   <= ex_mem_mem_to_reg;
        end
      end else if (dmem_ready) begin
        mem_wb_valid        <= 1'b1;
        mem_wb_reg_write_en <= cap_reg_write_en;
        mem_wb_alu_result   <= cap_alu;
        mem_wb_rd_addr      <= cap_rd;
        mem_wb_mem_to_reg   <= cap_mem_to_reg;
        mem_wb_load_data    <= cap_we ? 32'h0 : load_data(cap_funct3, cap_alu[1:0], dmem_rdata);
      end else if (timeout_hit) begin
        mem_bus_err         <= 1'b1;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle pulse when a misaligned access is refused in IDLE
  always_ff @(posedge clk) begin
    if (rst) mem_misaligned <= 1'b0;
    else     mem_misaligned <= (state == IDLE) && misaligned;
  end
`else
  assign mem_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (MEM_TIMEOUT = 4).
// Expected values come from a byte-level model of the access rules.
module tb_mem_stage;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_rs2_data;
  logic [2:0]  ex_mem_funct3;
  logic [4:0]  ex_mem_rd_addr;
  logic        ex_mem_reg_write_en;
  logic        ex_mem_mem_read_en;
  logic        ex_mem_mem_write_en;
  logic [1:0]  ex_mem_mem_to_reg;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_wb_valid;
  logic        mem_wb_reg_write_en;
  logic [31:0] mem_wb_alu_result;
  logic [31:0] mem_wb_load_data;
  logic [4:0]  mem_wb_rd_addr;
  logic [1:0]  mem_wb_mem_to_reg;
  logic        mem_bus_err;
  logic        mem_misaligned;

  int checks = 0;
  int errors = 0;

  logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk = ~clk;

  mem_stage #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_mem_valid        (ex_mem_valid),
    .ex_mem_alu_result   (ex_mem_alu_result),
    .ex_mem_rs2_data     (ex_mem_rs2_data),
    .ex_mem_funct3       (ex_mem_funct3),
    .ex_mem_rd_addr      (ex_mem_rd_addr),
    .ex_mem_reg_write_en (ex_mem_reg_write_en),
    .ex_mem_mem_read_en  (ex_mem_mem_read_en),
    .ex_mem_mem_write_en (ex_mem_mem_write_en),
    .ex_mem_mem_to_reg   (ex_mem_mem_to_reg),
    .mem_stall           (mem_stall),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_be             (dmem_be),
    .dmem_ready          (dmem_ready),
    .dmem_rdata          (dmem_rdata),
    .mem_wb_valid        (mem_wb_valid),
    .mem_wb_reg_write_en (mem_wb_reg_write_en),
    .mem_wb_alu_result   (mem_wb_alu_result),
    .mem_wb_load_data    (mem_wb_load_data),
    .mem_wb_rd_addr      (mem_wb_rd_addr),
    .mem_wb_mem_to_reg   (mem_wb_mem_to_reg),
    .mem_bus_err         (mem_bus_err),
    .mem_misaligned      (mem_misaligned)
  );

  // ---------------- reference model ----------------
  function automatic int access_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // First byte touched: low address bits rounded down to the access size
  function automatic int lane_of(input logic [2:0] f3, input logic [31:0] addr);
    int b = int'(addr[1:0]);
    return b - (b % access_size(f3));
  endfunction

  function automatic bit misaligned_access(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % access_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be = '0;
    int off = lane_of(f3, addr);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + access_size(f3)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int s = access_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int s = access_size(f3);
    logic [31:0] v, mask;
    v    = rdata >> (8 * lane_of(f3, addr));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v    = v & mask;
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    ex_mem_valid        = 1'b0;
    ex_mem_alu_result   = $urandom;
    ex_mem_rs2_data     = $urandom;
    ex_mem_funct3       = 3'($urandom);
    ex_mem_rd_addr      = 5'($urandom);
    ex_mem_reg_write_en = 1'($urandom);
    ex_mem_mem_read_en  = 1'($urandom);
    ex_mem_mem_write_en = 1'($urandom);
    ex_mem_mem_to_reg   = 2'($urandom);
  endtask

  // Non-memory instruction (or bubble when valid = 0): one-cycle latency
  task automatic alu_op(input string name, input logic valid, input logic [31:0] alu,
                        input logic [4:0] rd, input logic wen, input logic [1:0] m2r);
    drive_bubble();
    ex_mem_valid        = valid;
    ex_mem_alu_result   = alu;
    ex_mem_rd_addr      = rd;
    ex_mem_reg_write_en = wen;
    ex_mem_mem_to_reg   = m2r;
    if (valid) begin
      ex_mem_mem_read_en  = 1'b0;
      ex_mem_mem_write_en = 1'b0;
    end
    dmem_ready = 1'($urandom);  // ignored in IDLE
    dmem_rdata = $urandom;
    tick();
    drive_bubble();
    dmem_ready = 1'b0;
    checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_ctrl: got req/stall %b expected 00", name, {dmem_req, mem_stall});
    end
    checks++;
    if (valid) begin
      if ({mem_wb_valid, mem_wb_reg_write_en, mem_wb_rd_addr, mem_wb_mem_to_reg,
           mem_wb_alu_result, mem_wb_load_data} !== {1'b1, wen, rd, m2r, alu, 32'h0}) begin
        errors++;
        $display("FAIL %s wb: got v=%b we=%b rd=%0d m2r=%0d alu=%h ld=%h expected v=1 we=%b rd=%0d m2r=%0d alu=%h ld=0",
                 name, mem_wb_valid, mem_wb_reg_write_en, mem_wb_rd_addr, mem_wb_mem_to_reg,
                 mem_wb_alu_result, mem_wb_load_data, wen, rd, m2r, alu);
      end
    end else if ({mem_wb_valid, mem_wb_reg_write_en} !== 2'b00) begin
      errors++;
      $display("FAIL %s bubble: got valid/wen %b expected 00", name, {mem_wb_valid, mem_wb_reg_write_en});
    end
  endtask

  // Load/store; wait_n = BUS cycle in which dmem_ready rises (0 = never)
  task automatic mem_op(input string name, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic rd_en, input logic wr_en,
                        input logic [4:0] rd, input logic wen, input logic [1:0] m2r,
                        input logic [31:0] rdata, input int wait_n,
                        output logic [31:0] got_load, output int got_stall,
                        output logic [68:0] got_bus1);
    bit          exp_trap;
    bit          exp_done;
    logic [31:0] exp_ld;
    logic [68:0] exp_bus;
    logic [68:0] got_bus;
    got_load  = 'x;
    got_bus1  = 'x;
    got_stall = 0;
    exp_trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    exp_trap  = misaligned_access(f3, addr);
`endif
    exp_done = (wait_n >= 1) && (wait_n <= TB_TIMEOUT);
    exp_ld   = rd_en ? exp_load(f3, addr, rdata) : 32'h0;
    exp_bus  = {~rd_en, addr[31:2], 2'b00, exp_be(f3, addr), rd_en ? 32'h0 : exp_wdata(f3, rs2)};

    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_req: got %b expected 0", name, dmem_req);
    end
    ex_mem_valid        = 1'b1;
    ex_mem_alu_result   = addr;
    ex_mem_rs2_data     = rs2;
    ex_mem_funct3       = f3;
    ex_mem_rd_addr      = rd;
    ex_mem_reg_write_en = wen;
    ex_mem_mem_read_en  = rd_en;
    ex_mem_mem_write_en = wr_en;
    ex_mem_mem_to_reg   = m2r;
    dmem_ready          = 1'b0;
    tick();
    drive_bubble();

    checks++;
    if (mem_misaligned !== exp_trap) begin
      errors++;
      $display("FAIL %s misaligned_flag: got %b expected %b", name, mem_misaligned, exp_trap);
    end
    if (exp_trap) begin
      checks++;
      if ({dmem_req, mem_stall, mem_wb_valid, mem_wb_reg_write_en} !== 4'b0000) begin
        errors++;
        $display("FAIL %s trap: got req/stall/valid/wen %b expected 0000", name,
                 {dmem_req, mem_stall, mem_wb_valid, mem_wb_reg_write_en});
      end
      tick();
      checks++;
      if ({mem_misaligned, dmem_req} !== 2'b00) begin
        errors++;
        $display("FAIL %s trap_pulse: got misaligned/req %b expected 00", name, {mem_misaligned, dmem_req});
      end
      return;
    end

    for (int c = 1; c <= TB_TIMEOUT; c++) begin
      got_stall += int'(mem_stall);
      checks++;
      if ({dmem_req, mem_wb_valid, mem_bus_err} !== 3'b100) begin
        errors++;
        $display("FAIL %s bus_ctrl c%0d: got req/valid/err %b expected 100", name, c,
                 {dmem_req, mem_wb_valid, mem_bus_err});
      end
      got_bus = {dmem_we, dmem_addr, dmem_be, rd_en ? 32'h0 : dmem_wdata};
      if (c == 1) got_bus1 = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
      checks++;
      if (got_bus !== exp_bus) begin
        errors++;
        $display("FAIL %s bus_fields c%0d: got we/addr/be/wdata %h expected %h", name, c, got_bus, exp_bus);
      end
      dmem_ready = (c == wait_n);
      dmem_rdata = (c == wait_n) ? rdata : $urandom;
      tick();
      if (c == wait_n) break;
    end
    dmem_ready = 1'b0;

    checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      errors++;
      $display("FAIL %s back_to_idle: got req/stall %b expected 00", name, {dmem_req, mem_stall});
    end
    checks++;
    if (got_stall !== (exp_done ? wait_n : TB_TIMEOUT)) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, got_stall,
               exp_done ? wait_n : TB_TIMEOUT);
    end
    got_load = mem_wb_load_data;
    checks++;
    if (exp_done) begin
      if ({mem_wb_valid, mem_wb_reg_write_en, mem_wb_rd_addr, mem_wb_mem_to_reg, mem_wb_alu_result,
           mem_wb_load_data, mem_bus_err} !== {1'b1, wen, rd, m2r, addr, exp_ld, 1'b0}) begin
        errors++;
        $display("FAIL %s wb: got v=%b we=%b rd=%0d m2r=%0d alu=%h ld=%h err=%b expected v=1 we=%b rd=%0d m2r=%0d alu=%h ld=%h err=0",
                 name, mem_wb_valid, mem_wb_reg_write_en, mem_wb_rd_addr, mem_wb_mem_to_reg,
                 mem_wb_alu_result, mem_wb_load_data, mem_bus_err, wen, rd, m2r, addr, exp_ld);
      end
    end else if ({mem_wb_valid, mem_wb_reg_write_en, mem_bus_err} !== 3'b001) begin
      errors++;
      $display("FAIL %s timeout_wb: got valid/wen/err %b expected 001", name,
               {mem_wb_valid, mem_wb_reg_write_en, mem_bus_err});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_bubble();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    tick();
    tick();
    checks++;
    if ({dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_bus_err, mem_misaligned} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b stall=%b we=%b addr=%h be=%h wdata=%h err=%b mis=%b expected all 0",
               dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_bus_err, mem_misaligned);
    end
    checks++;
    if ({mem_wb_valid, mem_wb_reg_write_en, mem_wb_alu_result, mem_wb_load_data,
         mem_wb_rd_addr, mem_wb_mem_to_reg} !== '0) begin
      errors++;
      $display("FAIL reset_wb: got v=%b we=%b alu=%h ld=%h rd=%0d m2r=%0d expected all 0",
               mem_wb_valid, mem_wb_reg_write_en, mem_wb_alu_result, mem_wb_load_data,
               mem_wb_rd_addr, mem_wb_mem_to_reg);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    alu_op("alu_1234", 1'b1, 32'h0000_1234, 5'd5, 1'b1, 2'b00);
    alu_op("alu_nowen", 1'b1, 32'hDEAD_BEEF, 5'd31, 1'b0, 2'b10);
    alu_op("bubble", 1'b0, 32'h1111_2222, 5'd7, 1'b1, 2'b01);
  endtask

  task automatic test_load_ext();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    mem_op("lb_103", 3'b000, 32'h103, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 32'h80FF_0000, 2, ld, st, bus);
    checks++;
    if (ld !== 32'hFFFF_FF80 || st !== 2) begin
      errors++;
      $display("FAIL lb_103_value: got data %h stall %0d expected ffffff80 stall 2", ld, st);
    end
    mem_op("lbu_103", 3'b100, 32'h103, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 32'h80FF_0000, 2, ld, st, bus);
    checks++;
    if (ld !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_103_value: got %h expected 00000080", ld);
    end
  endtask

  task automatic test_store();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    mem_op("sh_102", 3'b001, 32'h102, 32'hABCD_1234, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 32'h0, 1, ld, st, bus);
    checks++;
    if (bus !== {1'b1, 32'h0000_0100, 4'b1100, 32'h1234_1234}) begin
      errors++;
      $display("FAIL sh_102_bus: got we/addr/be/wdata %h expected 1/00000100/c/12341234", bus);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    mem_op("lw_timeout", 3'b010, 32'h200, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1, 2'b01, 32'h0, 0, ld, st, bus);
    tick();
    checks++;
    if ({mem_bus_err, dmem_req, mem_wb_valid} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_pulse: got err/req/valid %b expected 000", {mem_bus_err, dmem_req, mem_wb_valid});
    end
    // ready in the same cycle the count reaches the limit: ready wins
    mem_op("lw_ready_at_limit", 3'b010, 32'h204, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 2'b01,
           32'hCAFE_F00D, TB_TIMEOUT, ld, st, bus);
  endtask

  task automatic test_misaligned();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    mem_op("lw_102", 3'b010, 32'h102, 32'h0, 1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 32'h1234_5678, 1, ld, st, bus);
`ifndef MEM_MISALIGN_TRAP_EN
    checks++;
    if ({bus[68:36]} !== {1'b0, 32'h0000_0100} || bus[35:32] !== 4'hF || ld !== 32'h1234_5678) begin
      errors++;
      $display("FAIL lw_102_aligned: got we/addr %h be %h data %h expected 0/00000100 f 12345678",
               bus[68:36], bus[35:32], ld);
    end
`endif
  endtask

  task automatic test_both_enables();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    mem_op("rw_as_load", 3'b101, 32'h42, 32'h5555_5555, 1'b1, 1'b1, 5'd12, 1'b1, 2'b01,
           32'hBEEF_0000, 3, ld, st, bus);
    checks++;
    if (bus[68] !== 1'b0 || ld !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL rw_as_load_value: got we %b data %h expected 0 0000beef", bus[68], ld);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    mem_op("b2b_first", 3'b000, 32'h300, 32'h0000_00AA, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 32'h0, 1, ld, st, bus);
    mem_op("b2b_second", 3'b010, 32'h304, 32'h0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b01, 32'h0BAD_CAFE, 1, ld, st, bus);
    alu_op("b2b_alu", 1'b1, 32'h7777, 5'd10, 1'b1, 2'b00);
  endtask

  task automatic test_reset_in_bus();
    drive_bubble();
    ex_mem_valid        = 1'b1;
    ex_mem_alu_result   = 32'h400;
    ex_mem_funct3       = 3'b010;
    ex_mem_mem_read_en  = 1'b1;
    ex_mem_mem_write_en = 1'b0;
    ex_mem_reg_write_en = 1'b1;
    dmem_ready          = 1'b0;
    tick();
    drive_bubble();
    tick();
    rst = 1'b1;
    dmem_ready = 1'b1;
    tick();
    rst = 1'b0;
    dmem_ready = 1'b0;
    checks++;
    if ({dmem_req, mem_stall, mem_bus_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_bus_ctrl: got req/stall/err %b expected 000", {dmem_req, mem_stall, mem_bus_err});
    end
    checks++;
    if ({mem_wb_valid, mem_wb_reg_write_en, mem_wb_alu_result, mem_wb_load_data,
         mem_wb_rd_addr, mem_wb_mem_to_reg} !== '0) begin
      errors++;
      $display("FAIL rst_bus_wb: got v=%b we=%b alu=%h ld=%h rd=%0d m2r=%0d expected all 0",
               mem_wb_valid, mem_wb_reg_write_en, mem_wb_alu_result, mem_wb_load_data,
               mem_wb_rd_addr, mem_wb_mem_to_reg);
    end
    alu_op("after_rst_alu", 1'b1, 32'h5A5A, 5'd2, 1'b1, 2'b00);
  endtask

  task automatic test_random();
    logic [31:0] ld;
    int          st;
    logic [68:0] bus;
    int          kind;
    logic [2:0]  f3;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        alu_op("rand_alu", 1'b1, $urandom, 5'($urandom), 1'($urandom), 2'($urandom));
      end else if (kind == 1) begin
        alu_op("rand_bubble", 1'b0, $urandom, 5'($urandom), 1'($urandom), 2'($urandom));
      end else begin
        f3 = (kind == 2) ? load_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
        mem_op(kind == 2 ? "rand_load" : "rand_store", f3, $urandom, $urandom,
               kind == 2, (kind == 3) ? 1'b1 : 1'($urandom), 5'($urandom), 1'($urandom),
               2'($urandom), $urandom, int'($urandom_range(0, TB_TIMEOUT + 1)), ld, st, bus);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ext();
    test_store();
    test_timeout();
    test_misaligned();
    test_both_enables();
    test_back_to_back();
    test_reset_in_bus();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
